axi_lite_arbiter_2to1: RTL and testbench

Two-master to one-slave AXI4-Lite arbiter. It shares one BRAM controller, or any AXI4-Lite slave, between the CPU instruction port (s0) and data port (s1). This frees the second BRAM port for a loader or debug master. It carries one transaction at a time, with round-robin or fixed-priority grant, and adds no error responses of its own.

---
 rtl/axi_lite_arbiter_2to1.sv | 201 ++++++++++++++++++++
 tb/tb_axi_lite_arbiter_2to1.sv | 348 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_lite_arbiter_2to1.sv
// Two-master to one-slave AXI4-Lite arbiter. Carries one transaction at a time,
// grants round-robin or fixed-priority (s1 first), and routes responses to the granted master.
module axi_lite_arbiter_2to1 #(
    parameter int ADDR_WIDTH  = 32,
    parameter bit ROUND_ROBIN = 1'b1
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [ADDR_WIDTH-1:0] s0_axi_awaddr,
    input  logic [2:0]            s0_axi_awprot,
    input  logic                  s0_axi_awvalid,
    output logic                  s0_axi_awready,
    input  logic [31:0]           s0_axi_wdata,
    input  logic [3:0]            s0_axi_wstrb,
    input  logic                  s0_axi_wvalid,
    output logic                  s0_axi_wready,
    output logic [1:0]            s0_axi_bresp,
    output logic                  s0_axi_bvalid,
    input  logic                  s0_axi_bready,
    input  logic [ADDR_WIDTH-1:0] s0_axi_araddr,
    input  logic [2:0]            s0_axi_arprot,
    input  logic                  s0_axi_arvalid,
    output logic                  s0_axi_arready,
    output logic [31:0]           s0_axi_rdata,
    output logic [1:0]            s0_axi_rresp,
    output logic                  s0_axi_rvalid,
    input  logic                  s0_axi_rready,
    input  logic [ADDR_WIDTH-1:0] s1_axi_awaddr,
    input  logic [2:0]            s1_axi_awprot,
    input  logic                  s1_axi_awvalid,
    output logic                  s1_axi_awready,
    input  logic [31:0]           s1_axi_wdata,
    input  logic [3:0]            s1_axi_wstrb,
    input  logic                  s1_axi_wvalid,
    output logic                  s1_axi_wready,
    output logic [1:0]            s1_axi_bresp,
    output logic                  s1_axi_bvalid,
    input  logic                  s1_axi_bready,
    input  logic [ADDR_WIDTH-1:0] s1_axi_araddr,
    input  logic [2:0]            s1_axi_arprot,
    input  logic                  s1_axi_arvalid,
    output logic                  s1_axi_arready,
    output logic [31:0]           s1_axi_rdata,
    output logic [1:0]            s1_axi_rresp,
    output logic                  s1_axi_rvalid,
    input  logic                  s1_axi_rready,
    output logic [ADDR_WIDTH-1:0] m_axi_awaddr,
    output logic [2:0]            m_axi_awprot,
    output logic                  m_axi_awvalid,
    input  logic                  m_axi_awready,
    output logic [31:0]           m_axi_wdata,
    output logic [3:0]            m_axi_wstrb,
    output logic                  m_axi_wvalid,
    input  logic                  m_axi_wready,
    input  logic [1:0]            m_axi_bresp,
    input  logic                  m_axi_bvalid,
    output logic                  m_axi_bready,
    output logic [ADDR_WIDTH-1:0] m_axi_araddr,
    output logic [2:0]            m_axi_arprot,
    output logic                  m_axi_arvalid,
    input  logic                  m_axi_arready,
    input  logic [31:0]           m_axi_rdata,
    input  logic [1:0]            m_axi_rresp,
    input  logic                  m_axi_rvalid,
    output logic                  m_axi_rready
);

    typedef enum logic [2:0] {IDLE, RD_REQ, RD_RSP, WR_REQ, WR_RSP} state_t;

    state_t                r_state;
    logic                  r_last;
    logic                  r_gnt;
    logic                  r_awvalid, r_wvalid, r_arvalid;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [2:0]            r_prot;
    logic [31:0]           r_wdata;
    logic [3:0]            r_wstrb;

    logic [1:0]            w_wr_req, w_rd_req, w_req;
    logic                  w_grant, w_win, w_win_wr;
    logic                  w_aw_pend, w_w_pend;
    logic                  w_rd0, w_rd1, w_wr0, w_wr1;
    logic [ADDR_WIDTH-1:0] w_cap_addr;
    logic [2:0]            w_cap_prot;
    logic [31:0]           w_cap_wdata;
    logic [3:0]            w_cap_wstrb;

    always_comb begin
        w_wr_req = {s1_axi_awvalid & s1_axi_wvalid, s0_axi_awvalid & s0_axi_wvalid};
        w_rd_req = {s1_axi_arvalid, s0_axi_arvalid};
        w_req    = w_wr_req | w_rd_req;
        w_grant  = (r_state == IDLE) && (w_req != 2'b00);
        // NOTE: every branch assigns every output, so no latch can be inferred here.
        if (w_req == 2'b11) begin
            w_win = ROUND_ROBIN ? ~r_last : 1'b1;
        end else begin
            w_win = w_req[1];
        end
        w_win_wr = w_wr_req[w_win];
        if (w_win) begin
            w_cap_addr  = w_win_wr ? s1_axi_awaddr : s1_axi_araddr;
            w_cap_prot  = w_win_wr ? s1_axi_awprot : s1_axi_arprot;
            w_cap_wdata = s1_axi_wdata;
            w_cap_wstrb = s1_axi_wstrb;
        end else begin
            w_cap_addr  = w_win_wr ? s0_axi_awaddr : s0_axi_araddr;
            w_cap_prot  = w_win_wr ? s0_axi_awprot : s0_axi_arprot;
            w_cap_wdata = s0_axi_wdata;
            w_cap_wstrb = s0_axi_wstrb;
        end
    end

    // A channel stays pending until its own handshake; both clear -> response phase.
    assign w_aw_pend = r_awvalid & ~m_axi_awready;
    assign w_w_pend  = r_wvalid & ~m_axi_wready;

    // NOTE: sequential state uses non-blocking assignments so all flops see pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= IDLE;
            r_last    <= 1'b1;
            r_gnt     <= 1'b0;
            r_awvalid <= 1'b0;
            r_wvalid  <= 1'b0;
            r_arvalid <= 1'b0;
            r_addr    <= '0;
            r_prot    <= '0;
            r_wdata   <= '0;
            r_wstrb   <= '0;
        end else begin
            case (r_state)
                IDLE: if (w_grant) begin
                    r_gnt  <= w_win;
                    r_last <= w_win;
                    r_addr <= w_cap_addr;
                    r_prot <= w_cap_prot;
                    if (w_win_wr) begin
                        r_wdata   <= w_cap_wdata;
                        r_wstrb   <= w_cap_wstrb;
                        r_awvalid <= 1'b1;
                        r_wvalid  <= 1'b1;
                        r_state   <= WR_REQ;
                    end else begin
                        r_arvalid <= 1'b1;
                        r_state   <= RD_REQ;
                    end
                end
                RD_REQ: if (m_axi_arready) begin
                    r_arvalid <= 1'b0;
                    r_state   <= RD_RSP;
                end
                RD_RSP: if (m_axi_rvalid && m_axi_rready) r_state <= IDLE;
                WR_REQ: begin
                    r_awvalid <= w_aw_pend;
                    r_wvalid  <= w_w_pend;
                    if (!w_aw_pend && !w_w_pend) r_state <= WR_RSP;
                end
                WR_RSP: if (m_axi_bvalid && m_axi_bready) r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

    assign s0_axi_awready = w_grant & ~w_win & w_win_wr;
    assign s0_axi_wready  = w_grant & ~w_win & w_win_wr;
    assign s0_axi_arready = w_grant & ~w_win & ~w_win_wr;
    assign s1_axi_awready = w_grant & w_win & w_win_wr;
    assign s1_axi_wready  = w_grant & w_win & w_win_wr;
    assign s1_axi_arready = w_grant & w_win & ~w_win_wr;

    // Read and write share one address register since only one transaction is in flight.
    assign m_axi_awaddr  = r_addr;
    assign m_axi_awprot  = r_prot;
    assign m_axi_awvalid = r_awvalid;
    assign m_axi_wdata   = r_wdata;
    assign m_axi_wstrb   = r_wstrb;
    assign m_axi_wvalid  = r_wvalid;
    assign m_axi_araddr  = r_addr;
    assign m_axi_arprot  = r_prot;
    assign m_axi_arvalid = r_arvalid;

    assign w_rd0 = (r_state == RD_RSP) && !r_gnt;
    assign w_rd1 = (r_state == RD_RSP) && r_gnt;
    assign w_wr0 = (r_state == WR_RSP) && !r_gnt;
    assign w_wr1 = (r_state == WR_RSP) && r_gnt;

    assign m_axi_rready = (w_rd0 & s0_axi_rready) | (w_rd1 & s1_axi_rready);
    assign m_axi_bready = (w_wr0 & s0_axi_bready) | (w_wr1 & s1_axi_bready);

    assign s0_axi_rvalid = w_rd0 & m_axi_rvalid;
    assign s0_axi_rdata  = w_rd0 ? m_axi_rdata : '0;
    assign s0_axi_rresp  = w_rd0 ? m_axi_rresp : '0;
    assign s1_axi_rvalid = w_rd1 & m_axi_rvalid;
    assign s1_axi_rdata  = w_rd1 ? m_axi_rdata : '0;
    assign s1_axi_rresp  = w_rd1 ? m_axi_rresp : '0;
    assign s0_axi_bvalid = w_wr0 & m_axi_bvalid;
    assign s0_axi_bresp  = w_wr0 ? m_axi_bresp : '0;
    assign s1_axi_bvalid = w_wr1 & m_axi_bvalid;
    assign s1_axi_bresp  = w_wr1 ? m_axi_bresp : '0;

endmodule

// File: tb/tb_axi_lite_arbiter_2to1.sv
// Directed bench for axi_lite_arbiter_2to1: the bench plays both masters and the slave,
// with a response scoreboard; a second fixed-priority instance shares all inputs.
module tb_axi_lite_arbiter_2to1;

    localparam int AW = 32;

    typedef struct {
        bit          mst;
        logic [31:0] data;
        logic [1:0]  resp;
    } rsp_t;

    logic clk = 1'b0;
    logic reset_n;

    logic [AW-1:0] s_awaddr [2];
    logic [2:0]    s_awprot [2];
    logic [31:0]   s_wdata  [2];
    logic [3:0]    s_wstrb  [2];
    logic [AW-1:0] s_araddr [2];
    logic [2:0]    s_arprot [2];
    logic [1:0]    s_awvalid, s_wvalid, s_bready, s_arvalid, s_rready;

    logic [1:0]    s_awready, s_wready, s_bvalid, s_arready, s_rvalid;
    logic [1:0]    s_bresp [2];
    logic [1:0]    s_rresp [2];
    logic [31:0]   s_rdata [2];

    logic [1:0]    f_awready, f_wready, f_bvalid, f_arready, f_rvalid;
    logic [1:0]    f_bresp [2];
    logic [1:0]    f_rresp [2];
    logic [31:0]   f_rdata [2];

    logic [AW-1:0] m_awaddr, m_araddr, fm_awaddr, fm_araddr;
    logic [2:0]    m_awprot, m_arprot, fm_awprot, fm_arprot;
    logic [31:0]   m_wdata, fm_wdata;
    logic [3:0]    m_wstrb, fm_wstrb;
    logic          m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready;
    logic          fm_awvalid, fm_wvalid, fm_bready, fm_arvalid, fm_rready;

    logic          m_awready, m_wready, m_bvalid, m_arready, m_rvalid;
    logic [1:0]    m_bresp, m_rresp;
    logic [31:0]   m_rdata;

    logic [31:0]   mem_word;
    rsp_t          rd_q [$];
    rsp_t          wr_q [$];
    bit            ga_q [$];
    bit            gb_q [$];
    int            n_chk = 0;
    int            n_err = 0;

    always #5 clk = ~clk;

    axi_lite_arbiter_2to1 #(.ADDR_WIDTH(AW), .ROUND_ROBIN(1'b1)) u_dut (
        .clk(clk), .reset_n(reset_n),
        .s0_axi_awaddr(s_awaddr[0]), .s0_axi_awprot(s_awprot[0]), .s0_axi_awvalid(s_awvalid[0]),
        .s0_axi_awready(s_awready[0]), .s0_axi_wdata(s_wdata[0]), .s0_axi_wstrb(s_wstrb[0]),
        .s0_axi_wvalid(s_wvalid[0]), .s0_axi_wready(s_wready[0]), .s0_axi_bresp(s_bresp[0]),
        .s0_axi_bvalid(s_bvalid[0]), .s0_axi_bready(s_bready[0]), .s0_axi_araddr(s_araddr[0]),
        .s0_axi_arprot(s_arprot[0]), .s0_axi_arvalid(s_arvalid[0]), .s0_axi_arready(s_arready[0]),
        .s0_axi_rdata(s_rdata[0]), .s0_axi_rresp(s_rresp[0]), .s0_axi_rvalid(s_rvalid[0]),
        .s0_axi_rready(s_rready[0]),
        .s1_axi_awaddr(s_awaddr[1]), .s1_axi_awprot(s_awprot[1]), .s1_axi_awvalid(s_awvalid[1]),
        .s1_axi_awready(s_awready[1]), .s1_axi_wdata(s_wdata[1]), .s1_axi_wstrb(s_wstrb[1]),
        .s1_axi_wvalid(s_wvalid[1]), .s1_axi_wready(s_wready[1]), .s1_axi_bresp(s_bresp[1]),
        .s1_axi_bvalid(s_bvalid[1]), .s1_axi_bready(s_bready[1]), .s1_axi_araddr(s_araddr[1]),
        .s1_axi_arprot(s_arprot[1]), .s1_axi_arvalid(s_arvalid[1]), .s1_axi_arready(s_arready[1]),
        .s1_axi_rdata(s_rdata[1]), .s1_axi_rresp(s_rresp[1]), .s1_axi_rvalid(s_rvalid[1]),
        .s1_axi_rready(s_rready[1]),
        .m_axi_awaddr(m_awaddr), .m_axi_awprot(m_awprot), .m_axi_awvalid(m_awvalid),
        .m_axi_awready(m_awready), .m_axi_wdata(m_wdata), .m_axi_wstrb(m_wstrb),
        .m_axi_wvalid(m_wvalid), .m_axi_wready(m_wready), .m_axi_bresp(m_bresp),
        .m_axi_bvalid(m_bvalid), .m_axi_bready(m_bready), .m_axi_araddr(m_araddr),
        .m_axi_arprot(m_arprot), .m_axi_arvalid(m_arvalid), .m_axi_arready(m_arready),
        .m_axi_rdata(m_rdata), .m_axi_rresp(m_rresp), .m_axi_rvalid(m_rvalid),
        .m_axi_rready(m_rready)
    );

    axi_lite_arbiter_2to1 #(.ADDR_WIDTH(AW), .ROUND_ROBIN(1'b0)) u_dut_fixed (
        .clk(clk), .reset_n(reset_n),
        .s0_axi_awaddr(s_awaddr[0]), .s0_axi_awprot(s_awprot[0]), .s0_axi_awvalid(s_awvalid[0]),
        .s0_axi_awready(f_awready[0]), .s0_axi_wdata(s_wdata[0]), .s0_axi_wstrb(s_wstrb[0]),
        .s0_axi_wvalid(s_wvalid[0]), .s0_axi_wready(f_wready[0]), .s0_axi_bresp(f_bresp[0]),
        .s0_axi_bvalid(f_bvalid[0]), .s0_axi_bready(s_bready[0]), .s0_axi_araddr(s_araddr[0]),
        .s0_axi_arprot(s_arprot[0]), .s0_axi_arvalid(s_arvalid[0]), .s0_axi_arready(f_arready[0]),
        .s0_axi_rdata(f_rdata[0]), .s0_axi_rresp(f_rresp[0]), .s0_axi_rvalid(f_rvalid[0]),
        .s0_axi_rready(s_rready[0]),
        .s1_axi_awaddr(s_awaddr[1]), .s1_axi_awprot(s_awprot[1]), .s1_axi_awvalid(s_awvalid[1]),
        .s1_axi_awready(f_awready[1]), .s1_axi_wdata(s_wdata[1]), .s1_axi_wstrb(s_wstrb[1]),
        .s1_axi_wvalid(s_wvalid[1]), .s1_axi_wready(f_wready[1]), .s1_axi_bresp(f_bresp[1]),
        .s1_axi_bvalid(f_bvalid[1]), .s1_axi_bready(s_bready[1]), .s1_axi_araddr(s_araddr[1]),
        .s1_axi_arprot(s_arprot[1]), .s1_axi_arvalid(s_arvalid[1]), .s1_axi_arready(f_arready[1]),
        .s1_axi_rdata(f_rdata[1]), .s1_axi_rresp(f_rresp[1]), .s1_axi_rvalid(f_rvalid[1]),
        .s1_axi_rready(s_rready[1]),
        .m_axi_awaddr(fm_awaddr), .m_axi_awprot(fm_awprot), .m_axi_awvalid(fm_awvalid),
        .m_axi_awready(m_awready), .m_axi_wdata(fm_wdata), .m_axi_wstrb(fm_wstrb),
        .m_axi_wvalid(fm_wvalid), .m_axi_wready(m_wready), .m_axi_bresp(m_bresp),
        .m_axi_bvalid(m_bvalid), .m_axi_bready(fm_bready), .m_axi_araddr(fm_araddr),
        .m_axi_arprot(fm_arprot), .m_axi_arvalid(fm_arvalid), .m_axi_arready(m_arready),
        .m_axi_rdata(m_rdata), .m_axi_rresp(m_rresp), .m_axi_rvalid(m_rvalid),
        .m_axi_rready(fm_rready)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Pops the scoreboard whenever a response handshake completes on either master port.
    task automatic mon();
        rsp_t e;
        for (int m = 0; m < 2; m++) begin
            if (s_rvalid[m] && s_rready[m]) begin
                if (rd_q.size() == 0) begin
                    check("rd unexpected", 32'(s_rvalid[m]), 32'd0);
                end else begin
                    e = rd_q.pop_front();
                    check("rd master", 32'(m), 32'(e.mst));
                    check("rd data", s_rdata[m], e.data);
                    check("rd resp", 32'(s_rresp[m]), 32'(e.resp));
                end
            end
            if (s_bvalid[m] && s_bready[m]) begin
                if (wr_q.size() == 0) begin
                    check("wr unexpected", 32'(s_bvalid[m]), 32'd0);
                end else begin
                    e = wr_q.pop_front();
                    check("wr master", 32'(m), 32'(e.mst));
                    check("wr bresp", 32'(s_bresp[m]), 32'(e.resp));
                end
            end
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
        mon();
    endtask

    initial begin
        reset_n   = 1'b1;
        s_awvalid = '0; s_wvalid = '0; s_arvalid = '0;
        s_bready  = 2'b11; s_rready = 2'b11;
        for (int i = 0; i < 2; i++) begin
            s_awaddr[i] = '0; s_awprot[i] = '0; s_wdata[i] = '0;
            s_wstrb[i]  = '0; s_araddr[i] = '0; s_arprot[i] = '0;
        end
        m_awready = 1'b0; m_wready = 1'b0; m_bvalid = 1'b0; m_bresp = '0;
        m_arready = 1'b0; m_rvalid = 1'b0; m_rresp = '0; m_rdata = '0;
        mem_word  = 32'hAAAA_AAAA;

        // reset state
        #2 reset_n = 1'b0;
        #2;
        check("rst s_arready", 32'(s_arready), 32'd0);
        check("rst s_awready", 32'(s_awready | s_wready), 32'd0);
        check("rst s_rvalid", 32'(s_rvalid | s_bvalid), 32'd0);
        check("rst m_valid", 32'({m_arvalid, m_awvalid, m_wvalid}), 32'd0);
        check("rst m_ready", 32'({m_rready, m_bready}), 32'd0);
        check("rst m_araddr", m_araddr, 32'd0);
        next_cycle();
        reset_n = 1'b1;

        // single s0 read, zero-wait slave
        s_arvalid[0] = 1'b1; s_araddr[0] = 32'h0000_0100; s_arprot[0] = 3'b010;
        rd_q.push_back('{mst: 1'b0, data: 32'hDEAD_BEEF, resp: 2'b00});
        mid();
        check("t1 s0 arready", 32'(s_arready), 32'b01);
        next_cycle();
        s_arvalid[0] = 1'b0; m_arready = 1'b1;
        mid();
        check("t1 m_arvalid", 32'(m_arvalid), 32'd1);
        check("t1 m_araddr", m_araddr, 32'h0000_0100);
        check("t1 m_arprot", 32'(m_arprot), 32'd2);
        next_cycle();
        m_arready = 1'b0; m_rvalid = 1'b1; m_rdata = 32'hDEAD_BEEF; m_rresp = 2'b00;
        mid();
        check("t1 s0 rvalid", 32'(s_rvalid), 32'b01);
        check("t1 s1 rdata", s_rdata[1], 32'd0);
        next_cycle();
        m_rvalid = 1'b0; m_rdata = '0;
        mid();
        check("t1 idle", 32'({m_arvalid, s_rvalid}), 32'd0);

        // continuous reads from both masters: round-robin vs fixed priority
        @(posedge clk); #2 reset_n = 1'b0;
        next_cycle();
        reset_n = 1'b1;
        s_arvalid = 2'b11; s_araddr[0] = 32'h1000; s_araddr[1] = 32'h2000;
        m_arready = 1'b1; m_rvalid = 1'b1; m_rdata = 32'h5A5A_0000; m_rresp = 2'b00;
        ga_q = '{1'b0, 1'b1, 1'b0, 1'b1};
        gb_q = '{1'b1, 1'b1, 1'b1, 1'b1};
        for (int i = 0; i < 4; i++) rd_q.push_back('{mst: ga_q[i], data: 32'h5A5A_0000, resp: 2'b00});
        for (int c = 0; c < 12; c++) begin
            mid();
            if (s_arready != 2'b00) begin
                if (ga_q.size() == 0) check("rr extra grant", 32'(s_arready), 32'd0);
                else check("rr grant", 32'(s_arready), ga_q.pop_front() ? 32'd2 : 32'd1);
            end
            if (f_arready != 2'b00) begin
                if (gb_q.size() == 0) check("fixed extra grant", 32'(f_arready), 32'd0);
                else check("fixed grant", 32'(f_arready), gb_q.pop_front() ? 32'd2 : 32'd1);
            end
            next_cycle();
        end
        s_arvalid = '0; m_rvalid = 1'b0; m_arready = 1'b0;
        check("rr grants seen", 32'(ga_q.size()), 32'd0);
        check("fixed grants seen", 32'(gb_q.size()), 32'd0);

        // s1 write; wready in cycle 1, awready in cycle 3
        s_awvalid[1] = 1'b1; s_wvalid[1] = 1'b1; s_awaddr[1] = 32'h0000_0200;
        s_wdata[1] = 32'h1234_5678; s_wstrb[1] = 4'b0011;
        wr_q.push_back('{mst: 1'b1, data: 32'd0, resp: 2'b00});
        mid();
        check("t3 s1 aw/w ready", 32'({s_awready, s_wready}), 32'b1010);
        next_cycle();
        s_awvalid[1] = 1'b0; s_wvalid[1] = 1'b0; m_wready = 1'b1;
        mid();
        check("t3 m aw/w valid", 32'({m_awvalid, m_wvalid}), 32'b11);
        check("t3 m_awaddr", m_awaddr, 32'h0000_0200);
        check("t3 m_wstrb", 32'(m_wstrb), 32'b0011);
        for (int b = 0; b < 4; b++) if (m_wvalid && m_wready && m_wstrb[b]) mem_word[8*b +: 8] = m_wdata[8*b +: 8];
        next_cycle();
        m_wready = 1'b0;
        mid();
        check("t3 c2 aw/w valid", 32'({m_awvalid, m_wvalid}), 32'b10);
        next_cycle();
        m_awready = 1'b1;
        mid();
        check("t3 c3 awvalid held", 32'(m_awvalid), 32'd1);
        check("t3 c3 awaddr", m_awaddr, 32'h0000_0200);
        next_cycle();
        m_awready = 1'b0;
        mid();
        check("t3 wrsp no bvalid", 32'({m_awvalid, s_bvalid}), 32'd0);
        check("t3 m_bready", 32'(m_bready), 32'd1);
        next_cycle();
        m_bvalid = 1'b1; m_bresp = 2'b00;
        mid();
        check("t3 s1 bvalid", 32'(s_bvalid), 32'b10);
        check("t3 mem", mem_word, 32'hAAAA_5678);
        next_cycle();
        m_bvalid = 1'b0;

        // s0 presents write and read together: write first, SLVERR read after
        s_awvalid[0] = 1'b1; s_wvalid[0] = 1'b1; s_awaddr[0] = 32'h300; s_wdata[0] = 32'h0F0F_0F0F;
        s_wstrb[0] = 4'hF; s_arvalid[0] = 1'b1; s_araddr[0] = 32'h304;
        m_awready = 1'b1; m_wready = 1'b1; m_arready = 1'b1;
        wr_q.push_back('{mst: 1'b0, data: 32'd0, resp: 2'b00});
        rd_q.push_back('{mst: 1'b0, data: 32'hCAFE_F00D, resp: 2'b10});
        mid();
        check("t4 write first", 32'({s_awready, s_arready}), 32'b0100);
        next_cycle();
        s_awvalid[0] = 1'b0; s_wvalid[0] = 1'b0;
        mid();
        check("t4 m aw/w valid", 32'({m_awvalid, m_wvalid}), 32'b11);
        next_cycle();
        m_bvalid = 1'b1;
        mid();
        check("t4 wrsp no arready", 32'({m_awvalid, s_arready}), 32'd0);
        next_cycle();
        m_bvalid = 1'b0;
        mid();
        check("t4 read next", 32'(s_arready), 32'b01);
        next_cycle();
        s_arvalid[0] = 1'b0;
        mid();
        check("t4 m_araddr", m_araddr, 32'h304);
        next_cycle();
        m_rvalid = 1'b1; m_rdata = 32'hCAFE_F00D; m_rresp = 2'b10;
        mid();
        check("t4 slverr", 32'(s_rresp[0]), 32'd2);
        next_cycle();
        m_rvalid = 1'b0; m_awready = 1'b0; m_wready = 1'b0;

        // s1 read stalled by rready low for 5 cycles while s0 waits
        s_arvalid[1] = 1'b1; s_araddr[1] = 32'h400;
        rd_q.push_back('{mst: 1'b1, data: 32'h0BAD_F00D, resp: 2'b00});
        mid();
        check("t5 s1 grant", 32'(s_arready), 32'b10);
        next_cycle();
        s_arvalid[1] = 1'b0; s_rready[1] = 1'b0;
        s_arvalid[0] = 1'b1; s_araddr[0] = 32'h500;
        mid();
        check("t5 s0 waits rdreq", 32'(s_arready), 32'd0);
        next_cycle();
        m_rvalid = 1'b1; m_rdata = 32'h0BAD_F00D; m_rresp = 2'b00;
        for (int i = 0; i < 5; i++) begin
            mid();
            check("t5 stall", 32'({m_rready, s_rvalid, s_arready}), 32'b0_10_00);
            next_cycle();
        end
        s_rready[1] = 1'b1;
        mid();
        check("t5 m_rready", 32'(m_rready), 32'd1);
        next_cycle();
        m_rvalid = 1'b0;
        mid();
        check("t5 s0 granted", 32'(s_arready), 32'b01);
        next_cycle();
        s_arvalid[0] = 1'b0; s_rready[0] = 1'b0;
        mid();
        check("t5 m_araddr", m_araddr, 32'h500);
        next_cycle();
        m_rvalid = 1'b1; m_rdata = 32'h7777_7777;

        // reset during RD_RSP
        mid();
        check("t6 in rd_rsp", 32'(s_rvalid), 32'b01);
        #1 reset_n = 1'b0;
        #1;
        check("t6 rst rvalid", 32'({s_rvalid, m_rready, m_arvalid}), 32'd0);
        check("t6 rst rdata", s_rdata[0], 32'd0);
        check("t6 rst araddr", m_araddr, 32'd0);
        next_cycle();
        reset_n = 1'b1; m_rvalid = 1'b0; s_rready[0] = 1'b1;
        s_arvalid = 2'b11; s_araddr[0] = 32'h600; s_araddr[1] = 32'h700;
        rd_q.push_back('{mst: 1'b0, data: 32'h1111_2222, resp: 2'b00});
        mid();
        check("t6 first tie s0", 32'(s_arready), 32'b01);
        next_cycle();
        s_arvalid = '0;
        mid();
        check("t6 m_araddr", m_araddr, 32'h600);
        next_cycle();
        m_rvalid = 1'b1; m_rdata = 32'h1111_2222;
        mid();
        next_cycle();
        m_rvalid = 1'b0;
        mid();
        check("t6 dropped not granted", 32'(s_arready), 32'd0);

        check("rd queue drained", 32'(rd_q.size()), 32'd0);
        check("wr queue drained", 32'(wr_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
